// File: rtl/counter_updown_param.sv
// Parametrised up/down counter: wrap/saturate, step size, parallel load, tc pulse, sticky overflow.
// Latency: one clk edge from inputs to registered outputs. No backpressure; optional prescaler via COUNTER_UPDOWN_PRESCALE_EN.
// Priority per edge is rst > load > enable.
module counter_updown_param #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              direction,
  input  logic [STEP_W-1:0] step,
  input  logic              saturate,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_ovf,
`ifdef COUNTER_UPDOWN_PRESCALE_EN
  input  logic [7:0]        prescale,
`endif
  output logic [WIDTH-1:0]  counter_out,
  output logic              tc,
  output logic              overflow
);

  localparam int EW = WIDTH + 1;

  // Arithmetic is carried one bit wider so MODULUS = 2**WIDTH and sums never overflow.
  localparam logic [EW-1:0] MOD_EXT  = EW'(MODULUS);
  localparam logic [EW-1:0] MAX_EXT  = EW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [EW-1:0]    cnt_ext;
  logic [EW-1:0]    step_ext;
  logic [EW-1:0]    sum;
  logic [EW-1:0]    up_next;
  logic [EW-1:0]    dn_next;
  logic             up_evt;
  logic             dn_evt;
  logic             advance;
  logic             evt;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_clamped;

  assign cnt_ext  = {1'b0, counter_out};
  assign step_ext = EW'(step);
  assign sum      = cnt_ext + step_ext;

  always_comb begin
    up_evt  = sum > MAX_EXT;
    up_next = sum;
    if (up_evt) begin
      up_next = saturate ? MAX_EXT : (sum - MOD_EXT);
    end

    dn_evt  = cnt_ext < step_ext;
    dn_next = cnt_ext - step_ext;
    if (dn_evt) begin
      dn_next = saturate ? '0 : (cnt_ext + MOD_EXT - step_ext);
    end
  end

`ifdef COUNTER_UPDOWN_PRESCALE_EN
  logic [7:0] presc_cnt;
  logic       presc_hit;

  assign presc_hit = (presc_cnt == prescale);
  assign advance   = enable && presc_hit;

  // Counts enabled cycles; holds when disabled, restarts on rst/load.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      presc_cnt <= '0;
    end else if (enable) begin
      presc_cnt <= presc_hit ? 8'd0 : presc_cnt + 8'd1;
    end
  end
`else
  assign advance = enable;
`endif

  always_comb begin
    count_next = counter_out;
    evt        = 1'b0;
    if (advance && (step != '0)) begin
      if (direction) begin
        count_next = WIDTH'(up_next);
        evt        = up_evt;
      end else begin
        count_next = WIDTH'(dn_next);
        evt        = dn_evt;
      end
    end
  end

  assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? WIDTH'(MAX_EXT) : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= RST_V;
      tc          <= 1'b0;
      overflow    <= 1'b0;
    end else if (load) begin
      counter_out <= load_clamped;
      tc          <= 1'b0;
    end else begin
      counter_out <= count_next;
      tc          <= evt;
      // A boundary event on the same edge as clr_ovf keeps the flag set.
      if (evt) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed bench for counter_updown_param (WIDTH=8, MODULUS=10, STEP_W=4), default build.
module tb_counter_updown_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       direction;
  logic [3:0] step;
  logic       saturate;
  logic       load;
  logic [7:0] load_val;
  logic       clr_ovf;
  logic [7:0] counter_out;
  logic       tc;
  logic       overflow;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  counter_updown_param #(
    .WIDTH(8), .MODULUS(10), .STEP_W(4), .RESET_VAL(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction),
    .step(step), .saturate(saturate), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .counter_out(counter_out), .tc(tc), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic tick(input logic [7:0] e_cnt, input logic e_tc, input logic e_ovf,
                      input string tag);
    exp_t e;
    sb.push_back('{cnt: e_cnt, tc: e_tc, ovf: e_ovf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    assert (counter_out === e.cnt) else begin
      mismatched++;
      $error("FAIL %s counter_out got %0d want %0d", tag, counter_out, e.cnt);
    end
    compared++;
    assert (tc === e.tc) else begin
      mismatched++;
      $error("FAIL %s tc got %b want %b", tag, tc, e.tc);
    end
    compared++;
    assert (overflow === e.ovf) else begin
      mismatched++;
      $error("FAIL %s overflow got %b want %b", tag, overflow, e.ovf);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b1; load_val = 8'd5;
    direction = 1'b1; step = 4'd1; saturate = 1'b0; clr_ovf = 1'b0;

    tick(8'd0, 1'b0, 1'b0, "reset1");
    tick(8'd0, 1'b0, 1'b0, "reset2");

    // Up count with wrap
    rst = 1'b0; load = 1'b0;
    for (int i = 1; i <= 9; i++) tick(8'(i), 1'b0, 1'b0, "up_count");
    tick(8'd0, 1'b1, 1'b1, "up_wrap");
    tick(8'd1, 1'b0, 1'b1, "up_after_wrap");
    clr_ovf = 1'b1;
    tick(8'd2, 1'b0, 1'b0, "clr_ovf");
    clr_ovf = 1'b0;

    // Down count with wrap
    load = 1'b1; load_val = 8'd4;
    tick(8'd4, 1'b0, 1'b0, "dn_load");
    load = 1'b0; direction = 1'b0; step = 4'd3;
    tick(8'd1, 1'b0, 1'b0, "dn_1");
    tick(8'd8, 1'b1, 1'b1, "dn_wrap");

    // Down count with saturate; overflow unchanged by load
    load = 1'b1; load_val = 8'd4; saturate = 1'b1;
    tick(8'd4, 1'b0, 1'b1, "sat_load");
    load = 1'b0;
    tick(8'd1, 1'b0, 1'b1, "sat_1");
    tick(8'd0, 1'b1, 1'b1, "sat_0");
    tick(8'd0, 1'b1, 1'b1, "sat_hold_a");
    tick(8'd0, 1'b1, 1'b1, "sat_hold_b");
    clr_ovf = 1'b1;
    tick(8'd0, 1'b1, 1'b1, "set_beats_clr");
    clr_ovf = 1'b0; enable = 1'b0;
    tick(8'd0, 1'b0, 1'b1, "sat_disabled");

    // Load priority over enable, and clamping
    load = 1'b1; load_val = 8'd12; enable = 1'b1; step = 4'd5;
    direction = 1'b1; saturate = 1'b0;
    tick(8'd9, 1'b0, 1'b1, "load_clamp");
    load_val = 8'd6;
    tick(8'd6, 1'b0, 1'b1, "load_6");

    // Hold cases
    load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) tick(8'd6, 1'b0, 1'b1, "hold_disabled");
    clr_ovf = 1'b1;
    tick(8'd6, 1'b0, 1'b0, "clr_while_idle");
    clr_ovf = 1'b0; enable = 1'b1; step = 4'd0;
    tick(8'd6, 1'b0, 1'b0, "hold_step0_a");
    tick(8'd6, 1'b0, 1'b0, "hold_step0_b");
    step = 4'd3;
    tick(8'd9, 1'b0, 1'b0, "exact_land_up");

    // Up saturate at the top bound
    saturate = 1'b1; step = 4'd2;
    tick(8'd9, 1'b1, 1'b1, "sat_up_top");

    // Exact landing on zero going down is not an event
    load = 1'b1; load_val = 8'd3; saturate = 1'b0; clr_ovf = 1'b1;
    tick(8'd3, 1'b0, 1'b1, "load_3");
    load = 1'b0; direction = 1'b0; step = 4'd3; clr_ovf = 1'b0;
    tick(8'd0, 1'b0, 1'b1, "exact_land_dn");
    step = 4'd1;
    tick(8'd9, 1'b1, 1'b1, "dn_wrap_step1");

    // Reset mid-operation overrides load and enable
    rst = 1'b1; load = 1'b1; load_val = 8'd7;
    tick(8'd0, 1'b0, 1'b0, "mid_reset");
    rst = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
- Parametrised up/down counter: the next-generation replacement for the fixed 8-bit up/down counter.
- Adds:
  - configurable width and modulus
  - variable step size
  - synchronous parallel load
  - wrap or saturate mode
  - terminal-count pulse and sticky overflow flag
- Used as a general event/timebase counter wherever a loadable, bounded count is needed.

Parameters:
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH.
- STEP_W, 4: width of the step input.
- RESET_VAL, 0: value loaded on reset. Must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  count enable
- direction  input  1  1 = count up, 0 = count down
- step  input  STEP_W  increment/decrement amount; 0 = hold
- saturate  input  1  1 = clamp at bounds, 0 = wrap modulo MODULUS
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- clr_ovf  input  1  clears the sticky overflow flag
- counter_out  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered)
- overflow  output  1  sticky boundary-event flag (registered)

Behaviour:
- All outputs are registered and update on the rising edge of clk.
- Priority per edge: rst > load > enable. direction and saturate are sampled each edge.
- Reset: counter_out = RESET_VAL, tc = 0, overflow = 0. Reset takes effect mid-operation regardless of load/enable.
- Load:
  - counter_out = load_val if load_val < MODULUS, else MODULUS-1 (clamped).
  - tc = 0; overflow is unchanged.
- Hold: when enable = 0 or step = 0, counter_out holds and tc = 0.
- Up count, enable = 1:
  - Compute sum = counter_out + step at WIDTH+1 bits, so there is no internal overflow.
  - If sum <= MODULUS-1: counter_out = sum.
  - Otherwise it is a boundary event:
    - wrap mode: counter_out = sum - MODULUS
    - saturate mode: counter_out = MODULUS-1
- Down count, enable = 1:
  - If counter_out >= step: counter_out = counter_out - step.
  - Otherwise it is a boundary event:
    - wrap mode: counter_out = counter_out + MODULUS - step
    - saturate mode: counter_out = 0
- Constraint: the step input value must be <= MODULUS-1. Larger values are out of contract and the bench does not drive them.
- Boundary event:
  - tc = 1 on the same edge the new count appears; otherwise tc = 0.
  - In saturate mode, each further enabled cycle at the bound that would cross it is a new event, so tc stays high continuously.
  - Landing exactly on a bound (MODULUS-1 going up, 0 going down) is not an event.
- overflow:
  - Set by any boundary event.
  - Cleared by clr_ovf.
  - If clr_ovf and an event occur on the same edge, the set wins (overflow = 1).
- When MODULUS = 2**WIDTH, wrap behaviour equals natural binary rollover.

Optional Feature:
- Macro: COUNTER_UPDOWN_PRESCALE_EN.
- Defined:
  - Adds port prescale, input, 8 bits.
  - An internal 8-bit prescaler counts enabled cycles. The count/step logic advances only when prescaler == prescale, after which the prescaler returns to 0.
  - The prescaler is cleared by rst and load, and holds when enable = 0.
  - prescale = 0 gives the same behaviour as when the macro is undefined.
  - tc/overflow are evaluated only on advancing cycles.
- Undefined: the prescale port and prescaler logic are absent; the counter advances on every enabled cycle.

Test Plan:
(All scenarios use WIDTH = 8, MODULUS = 10, STEP_W = 4.)
- Reset: rst = 1 for 2 edges with enable = 1, load = 1 -> counter_out = 0, tc = 0, overflow = 0.
- Up wrap: rst released, enable = 1, direction = 1, step = 1, saturate = 0 -> counts 1..9 over 9 edges; 10th edge gives counter_out = 0, tc = 1 for exactly that cycle, overflow = 1 thereafter. A clr_ovf pulse then gives overflow = 0.
- Down wrap and saturate:
  - load_val = 4, then direction = 0, step = 3, saturate = 0 -> 4, 1, 8 (tc = 1 at 8).
  - Repeat with saturate = 1 -> 4, 1, 0 (tc = 1), then 0 with tc held at 1 while enabled.
- Load priority and clamp: load = 1, load_val = 12, enable = 1, step = 5 -> counter_out = 9, tc = 0. load = 1, load_val = 6 -> counter_out = 6.
- Hold cases:
  - enable = 0 for 5 edges at count 6 -> counter_out stays 6, tc = 0.
  - step = 0 with enable = 1 -> stays 6.
  - Exact landing: up from 6 with step = 3 -> 9, tc = 0.
- Prescale (macro defined): prescale = 2, step = 1, up from 0 -> counter_out changes on every 3rd edge (0, 0, 1, 1, 1, 2, ...). A load mid-period restarts the 3-cycle cadence.
